// File: rtl/sal_sched_pkg.sv
// Shared DDR2 parameters and the command encoding used by the bank scheduler.
package sal_sched_pkg;

    localparam int DRAM_RA_WIDTH = 14;
    localparam int DRAM_CA_WIDTH = 10;
    localparam int DDR2_NUM_BK   = 8;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } dram_cmd_e;

    // Bank-address width; a single-bank build still needs a 1-bit field.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sal_sched_if.sv
// Bank-controller request/grant bundle plus the registered DRAM command bus.
interface sal_sched_if
    import sal_sched_pkg::*;
#(
    parameter int NUM_BK = DDR2_NUM_BK
) ();
    localparam int BA_W = bank_w(NUM_BK);

    logic [NUM_BK-1:0]                    act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i;
    logic [NUM_BK-1:0][DRAM_RA_WIDTH-1:0] ra_i;
    logic [NUM_BK-1:0][DRAM_CA_WIDTH-1:0] ca_i;
    logic [NUM_BK-1:0]                    act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o;
    dram_cmd_e                            cmd_o;
    logic [BA_W-1:0]                      ba_o;
    logic [DRAM_RA_WIDTH-1:0]             addr_o;

    // Scheduler side
    modport slave (
        input  act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
        output act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o, cmd_o, ba_o, addr_o
    );

    // Bank-controller / PHY side
    modport master (
        output act_req_i, rd_req_i, wr_req_i, pre_req_i, ref_req_i, ra_i, ca_i,
        input  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o, ref_gnt_o, cmd_o, ba_o, addr_o
    );

endinterface

// File: rtl/sal_timing_cntr.sv
// Inter-command spacing counter: reloads on its triggering grant, counts down
// to zero, and reports eligibility when it has reached zero.
module sal_timing_cntr #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] t_val,
    output logic          ok
);
    logic [TW-1:0] cnt;

    // Load t-1 so the next command lands exactly t cycles after the trigger;
    // 0 and 1 both mean the very next cycle is allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (load)       cnt <= (t_val == '0) ? '0 : t_val - 1'b1;
        else if (cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign ok = (cnt == '0);

endmodule

// File: rtl/sal_sched.sv
// Single-channel DRAM command scheduler: one grant per cycle across all banks,
// class priority REF > PRE > RD/WR > ACT, round-robin among banks, registered
// command output one cycle after the grant.
module sal_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BK = DDR2_NUM_BK,
    parameter int TW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] t_rrd_i,
    input  logic [TW-1:0] t_ccd_i,
    input  logic [TW-1:0] t_wtr_i,
    input  logic [TW-1:0] t_rtw_i,
    sal_sched_if.slave    bus
);
    localparam int BA_W = bank_w(NUM_BK);

    logic [BA_W-1:0]          rr_ptr;
    logic                     rrd_ok, ccd_ok, wtr_ok, rtw_ok;
    logic [NUM_BK-1:0]        conflict, rd_elig, wr_elig, act_elig;
    logic [BA_W:0]            pick_ref, pick_pre, pick_rw, pick_act;
    logic                     gnt_any;
    logic [BA_W-1:0]          gnt_bank;
    dram_cmd_e                gnt_cmd;
    logic [DRAM_RA_WIDTH-1:0] addr_nxt;
    logic [NUM_BK-1:0]        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    dram_cmd_e                cmd_q;
    logic [BA_W-1:0]          ba_q;
    logic [DRAM_RA_WIDTH-1:0] addr_q;

    // First requesting bank at or after ptr, wrapping; MSB is the found flag.
    function automatic logic [BA_W:0] rr_pick(input logic [NUM_BK-1:0] req,
                                              input logic [BA_W-1:0]   ptr);
        logic [BA_W:0] res;
        res = '0;
        for (int i = NUM_BK - 1; i >= 0; i--) begin
            int b;
            b = (int'(ptr) + i) % NUM_BK;
            if (req[b]) res = {1'b1, b[BA_W-1:0]};
        end
        return res;
    endfunction

    // A bank asking for RD and WR at once is malformed and gets neither.
    assign conflict = bus.rd_req_i & bus.wr_req_i;
    assign rd_elig  = bus.rd_req_i & ~conflict & {NUM_BK{ccd_ok & wtr_ok}};
    assign wr_elig  = bus.wr_req_i & ~conflict & {NUM_BK{ccd_ok & rtw_ok}};
    assign act_elig = bus.act_req_i & {NUM_BK{rrd_ok}};

    assign pick_ref = rr_pick(bus.ref_req_i, rr_ptr);
    assign pick_pre = rr_pick(bus.pre_req_i, rr_ptr);
    assign pick_rw  = rr_pick(rd_elig | wr_elig, rr_ptr);
    assign pick_act = rr_pick(act_elig, rr_ptr);

    // Class arbitration; ineligible classes simply fall through to the next.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_bank = '0;
        gnt_cmd  = CMD_NOP;
        addr_nxt = '0;
        act_gnt  = '0;
        rd_gnt   = '0;
        wr_gnt   = '0;
        pre_gnt  = '0;
        ref_gnt  = '0;
        if (rst_n) begin
            if (pick_ref[BA_W]) begin
                gnt_any  = 1'b1;
                gnt_bank = pick_ref[BA_W-1:0];
                gnt_cmd  = CMD_REF;
                ref_gnt[gnt_bank] = 1'b1;
            end else if (pick_pre[BA_W]) begin
                gnt_any  = 1'b1;
                gnt_bank = pick_pre[BA_W-1:0];
                gnt_cmd  = CMD_PRE;
                pre_gnt[gnt_bank] = 1'b1;
            end else if (pick_rw[BA_W]) begin
                gnt_any  = 1'b1;
                gnt_bank = pick_rw[BA_W-1:0];
                addr_nxt = DRAM_RA_WIDTH'(bus.ca_i[gnt_bank]);
                if (rd_elig[gnt_bank]) begin
                    gnt_cmd = CMD_RD;
                    rd_gnt[gnt_bank] = 1'b1;
                end else begin
                    gnt_cmd = CMD_WR;
                    wr_gnt[gnt_bank] = 1'b1;
                end
            end else if (pick_act[BA_W]) begin
                gnt_any  = 1'b1;
                gnt_bank = pick_act[BA_W-1:0];
                gnt_cmd  = CMD_ACT;
                addr_nxt = bus.ra_i[gnt_bank];
                act_gnt[gnt_bank] = 1'b1;
            end
        end
    end

    // Register the granted command and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= CMD_NOP;
            ba_q   <= '0;
            addr_q <= '0;
            rr_ptr <= '0;
        end else begin
            cmd_q  <= gnt_cmd;
            ba_q   <= gnt_bank;
            addr_q <= addr_nxt;
            if (gnt_any)
                rr_ptr <= (gnt_bank == BA_W'(NUM_BK - 1)) ? '0 : gnt_bank + 1'b1;
        end
    end

    sal_timing_cntr #(.TW(TW)) u_rrd (
        .clk(clk), .rst_n(rst_n), .load(gnt_cmd == CMD_ACT), .t_val(t_rrd_i), .ok(rrd_ok));
    sal_timing_cntr #(.TW(TW)) u_ccd (
        .clk(clk), .rst_n(rst_n), .load((gnt_cmd == CMD_RD) || (gnt_cmd == CMD_WR)),
        .t_val(t_ccd_i), .ok(ccd_ok));
    sal_timing_cntr #(.TW(TW)) u_wtr (
        .clk(clk), .rst_n(rst_n), .load(gnt_cmd == CMD_WR), .t_val(t_wtr_i), .ok(wtr_ok));
    sal_timing_cntr #(.TW(TW)) u_rtw (
        .clk(clk), .rst_n(rst_n), .load(gnt_cmd == CMD_RD), .t_val(t_rtw_i), .ok(rtw_ok));

    assign bus.act_gnt_o = act_gnt;
    assign bus.rd_gnt_o  = rd_gnt;
    assign bus.wr_gnt_o  = wr_gnt;
    assign bus.pre_gnt_o = pre_gnt;
    assign bus.ref_gnt_o = ref_gnt;
    assign bus.cmd_o     = cmd_q;
    assign bus.ba_o      = ba_q;
    assign bus.addr_o    = addr_q;

endmodule
